// File: rtl/fifo_loopback_pkg.sv
// fifo_loopback_pkg: shared FSM state encoding and default
// terminator / inserted character constants for fifo_loopback.
package fifo_loopback_pkg;

   // Holding-register FSM states
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_DATA  = 2'd1,
      ST_INS   = 2'd2
   } lb_state_t;

   // Default terminator (CR) and inserted character (LF)
   localparam logic [7:0] TERM_CHAR_DEF = 8'h0D;
   localparam logic [7:0] INS_CHAR_DEF  = 8'h0A;

endpackage

// File: rtl/loopback_counter.sv
// loopback_counter: free-running wrapping event counter.
// Ports: clk, rst (async, active-high), inc (count enable),
//        count (current value, wraps all-ones -> 0 silently).
module loopback_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/fifo_loopback.sv
// fifo_loopback: moves words from an FWFT RX FIFO to a TX FIFO
// through a one-word holding register, optionally inserting
// INS_CHAR after each forwarded TERM_CHAR (e.g. CR -> CR LF).
// Ports:
//   clk, rst          clock, async active-high reset
//   en                accept new words from the RX FIFO
//   expand_en         insert INS_CHAR after TERM_CHAR
//   rx_fifo_dout/empty/rd_en   RX FIFO read side (FWFT)
//   tx_fifo_din/full/wr_en     TX FIFO write side
//   rx_count/tx_count words popped / written (wrapping)
//   busy              holding register occupied
module fifo_loopback
   import fifo_loopback_pkg::*;
#(
   parameter int         DATA_W    = 8,
   parameter logic [7:0] TERM_CHAR = TERM_CHAR_DEF,
   parameter logic [7:0] INS_CHAR  = INS_CHAR_DEF,
   parameter int         CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              expand_en,
   input  logic [DATA_W-1:0] rx_fifo_dout,
   input  logic              rx_fifo_empty,
   output logic              rx_fifo_rd_en,
   output logic [DATA_W-1:0] tx_fifo_din,
   input  logic              tx_fifo_full,
   output logic              tx_fifo_wr_en,
   output logic [CNT_W-1:0]  rx_count,
   output logic [CNT_W-1:0]  tx_count,
   output logic              busy
);

   localparam logic [DATA_W-1:0] TERM_W = DATA_W'(TERM_CHAR);
   localparam logic [DATA_W-1:0] INS_W  = DATA_W'(INS_CHAR);

   lb_state_t         r_state;
   lb_state_t         w_state_nxt;
   logic [DATA_W-1:0] r_word;
   logic [DATA_W-1:0] w_word_nxt;

   logic w_wr;
   logic w_term_hit;
   logic w_pop;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_word  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_word  <= w_word_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_word_nxt  = r_word;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_pop) begin
               w_state_nxt = ST_DATA;
               w_word_nxt  = rx_fifo_dout;
            end
         end
         ST_DATA: begin
            if (w_wr) begin
               // A terminator blocks the pop so the insert slot
               // follows it directly.
               if (w_term_hit) begin
                  w_state_nxt = ST_INS;
                  w_word_nxt  = INS_W;
               end else if (w_pop) begin
                  w_state_nxt = ST_DATA;
                  w_word_nxt  = rx_fifo_dout;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
         end
         ST_INS: begin
            if (w_wr) begin
               if (w_pop) begin
                  w_state_nxt = ST_DATA;
                  w_word_nxt  = rx_fifo_dout;
               end else begin
                  w_state_nxt = ST_EMPTY;
               end
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
            w_word_nxt  = '0;
         end
      endcase
   end

   // Output logic; rst gating keeps strobes low during an
   // asynchronous reset before the state flops settle.
   always_comb begin
      w_wr = (r_state != ST_EMPTY) & ~tx_fifo_full & ~rst;
      w_term_hit = (r_state == ST_DATA) & expand_en
                 & (r_word == TERM_W);
      w_pop = en & ~rx_fifo_empty & ~rst
            & ((r_state == ST_EMPTY) | (w_wr & ~w_term_hit));
   end

   assign tx_fifo_wr_en = w_wr;
   assign tx_fifo_din   = w_wr ? r_word : '0;
   assign rx_fifo_rd_en = w_pop;
   assign busy          = (r_state != ST_EMPTY);

   loopback_counter #(
      .CNT_W (CNT_W)
   ) u_rx_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_pop),
      .count (rx_count)
   );

   loopback_counter #(
      .CNT_W (CNT_W)
   ) u_tx_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_wr),
      .count (tx_count)
   );

endmodule

// File: tb/tb_fifo_loopback.sv
// tb_fifo_loopback: directed checks of fifo_loopback, plus a
// CNT_W=4 instance sharing the same stimulus for counter wrap.
module tb_fifo_loopback;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       expand_en;
   logic [7:0] rx_fifo_dout;
   logic       rx_fifo_empty;
   logic       tx_fifo_full;

   logic        rx_fifo_rd_en;
   logic [7:0]  tx_fifo_din;
   logic        tx_fifo_wr_en;
   logic [15:0] rx_count;
   logic [15:0] tx_count;
   logic        busy;

   logic       rd4;
   logic [7:0] din4;
   logic       wr4;
   logic [3:0] rx_count4;
   logic [3:0] tx_count4;
   logic       busy4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_loopback dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .expand_en     (expand_en),
      .rx_fifo_dout  (rx_fifo_dout),
      .rx_fifo_empty (rx_fifo_empty),
      .rx_fifo_rd_en (rx_fifo_rd_en),
      .tx_fifo_din   (tx_fifo_din),
      .tx_fifo_full  (tx_fifo_full),
      .tx_fifo_wr_en (tx_fifo_wr_en),
      .rx_count      (rx_count),
      .tx_count      (tx_count),
      .busy          (busy)
   );

   fifo_loopback #(.CNT_W(4)) dut4 (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .expand_en     (expand_en),
      .rx_fifo_dout  (rx_fifo_dout),
      .rx_fifo_empty (rx_fifo_empty),
      .rx_fifo_rd_en (rd4),
      .tx_fifo_din   (din4),
      .tx_fifo_full  (tx_fifo_full),
      .tx_fifo_wr_en (wr4),
      .rx_count      (rx_count4),
      .tx_count      (tx_count4),
      .busy          (busy4)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cnt(input string tag,
                      input int xr, input int xt);
      chk({tag, ".rxc"}, 32'(rx_count), 32'(xr));
      chk({tag, ".txc"}, 32'(tx_count), 32'(xt));
   endtask

   // Drive RX head, check outputs mid-cycle, advance one clock.
   task automatic cyc(input string tag,
                      input logic [7:0] d, input logic e,
                      input logic xr, input logic xw,
                      input logic [7:0] xd, input logic xb);
      rx_fifo_dout  = d;
      rx_fifo_empty = e;
      #1;
      chk({tag, ".rd"},   32'(rx_fifo_rd_en), 32'(xr));
      chk({tag, ".wr"},   32'(tx_fifo_wr_en), 32'(xw));
      chk({tag, ".din"},  32'(tx_fifo_din),   32'(xd));
      chk({tag, ".busy"}, 32'(busy),          32'(xb));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      en            = 1'b1;
      expand_en     = 1'b0;
      rx_fifo_dout  = 8'h11;
      rx_fifo_empty = 1'b0;
      tx_fifo_full  = 1'b0;
      #2;
      chk("rst.rd",   32'(rx_fifo_rd_en), 0);
      chk("rst.wr",   32'(tx_fifo_wr_en), 0);
      chk("rst.din",  32'(tx_fifo_din),   0);
      chk("rst.busy", 32'(busy),          0);
      cnt("rst", 0, 0);
      @(posedge clk);
      #1;
      rx_fifo_empty = 1'b1;
      rst = 1'b0;

      // Plain stream 41,42,43
      cyc("t1a", 8'h41, 0, 1, 0, 8'h00, 0);
      cyc("t1b", 8'h42, 0, 1, 1, 8'h41, 1);
      cyc("t1c", 8'h43, 0, 1, 1, 8'h42, 1);
      cyc("t1d", 8'h00, 1, 0, 1, 8'h43, 1);
      cyc("t1e", 8'h00, 1, 0, 0, 8'h00, 0);
      cnt("t1", 3, 3);

      // Expansion: 41,0D,42 -> 41,0D,0A,42
      expand_en = 1'b1;
      cyc("t2a", 8'h41, 0, 1, 0, 8'h00, 0);
      cyc("t2b", 8'h0D, 0, 1, 1, 8'h41, 1);
      cyc("t2c", 8'h42, 0, 0, 1, 8'h0D, 1);
      cyc("t2d", 8'h42, 0, 1, 1, 8'h0A, 1);
      cyc("t2e", 8'h00, 1, 0, 1, 8'h42, 1);
      cyc("t2f", 8'h00, 1, 0, 0, 8'h00, 0);
      cnt("t2", 6, 7);

      // expand_en sampled in the cycle 0D is written
      expand_en = 1'b0;
      cyc("t2g", 8'h0D, 0, 1, 0, 8'h00, 0);
      cyc("t2h", 8'h0D, 0, 1, 1, 8'h0D, 1);
      expand_en = 1'b1;
      cyc("t2i", 8'h00, 1, 0, 1, 8'h0D, 1);
      cyc("t2j", 8'h00, 1, 0, 1, 8'h0A, 1);
      cyc("t2k", 8'h00, 1, 0, 0, 8'h00, 0);
      cnt("t2x", 8, 10);

      // Backpressure holding 55
      expand_en = 1'b0;
      cyc("t3a", 8'h55, 0, 1, 0, 8'h00, 0);
      tx_fifo_full = 1'b1;
      for (int i = 0; i < 5; i++)
         cyc("t3full", 8'h66, 0, 0, 0, 8'h00, 1);
      tx_fifo_full = 1'b0;
      cyc("t3b", 8'h66, 0, 1, 1, 8'h55, 1);
      cyc("t3c", 8'h00, 1, 0, 1, 8'h66, 1);
      tx_fifo_full = 1'b1;
      cyc("t3d", 8'h77, 0, 1, 0, 8'h00, 0);
      cyc("t3e", 8'h00, 1, 0, 0, 8'h00, 1);
      tx_fifo_full = 1'b0;
      cyc("t3f", 8'h00, 1, 0, 1, 8'h77, 1);
      cyc("t3g", 8'h00, 1, 0, 0, 8'h00, 0);
      cnt("t3", 11, 13);

      // en dropped with INS pending; expand_en flip ignored
      expand_en = 1'b1;
      cyc("t4a", 8'h0D, 0, 1, 0, 8'h00, 0);
      en = 1'b0;
      cyc("t4b", 8'h88, 0, 0, 1, 8'h0D, 1);
      expand_en = 1'b0;
      cyc("t4c", 8'h88, 0, 0, 1, 8'h0A, 1);
      cyc("t4d", 8'h88, 0, 0, 0, 8'h00, 0);
      cyc("t4e", 8'h88, 0, 0, 0, 8'h00, 0);
      cnt("t4", 12, 15);

      // Reset with INS pending
      en = 1'b1;
      expand_en = 1'b1;
      cyc("t5a", 8'h0D, 0, 1, 0, 8'h00, 0);
      cyc("t5b", 8'h00, 1, 0, 1, 8'h0D, 1);
      rst = 1'b1;
      rx_fifo_dout  = 8'h99;
      rx_fifo_empty = 1'b0;
      #1;
      chk("t5.rd",   32'(rx_fifo_rd_en), 0);
      chk("t5.wr",   32'(tx_fifo_wr_en), 0);
      chk("t5.din",  32'(tx_fifo_din),   0);
      chk("t5.busy", 32'(busy),          0);
      cnt("t5", 0, 0);
      chk("t5.rxc4", 32'(rx_count4), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("t5c", 8'h00, 1, 0, 0, 8'h00, 0);
      cnt("t5c", 0, 0);

      // 17 words: CNT_W=4 counters wrap to 1
      expand_en = 1'b0;
      for (int k = 0; k < 17; k++)
         cyc("t6", 8'(k + 1), 0, 1, k > 0,
             (k > 0) ? 8'(k) : 8'h00, k > 0);
      cyc("t6y", 8'h00, 1, 0, 1, 8'h11, 1);
      cyc("t6z", 8'h00, 1, 0, 0, 8'h00, 0);
      cnt("t6", 17, 17);
      chk("t6.rxc4", 32'(rx_count4), 1);
      chk("t6.txc4", 32'(tx_count4), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_loopback.md
FIFO_LOOPBACK -- requirements
Module: fifo_loopback

Interface
REQ-001 The module SHALL provide parameter DATA_W, default 8, giving the data path width in bits.
REQ-002 The module SHALL provide parameter TERM_CHAR, default 8'h0D, giving the byte that triggers insertion.
REQ-003 The module SHALL provide parameter INS_CHAR, default 8'h0A, giving the byte inserted after TERM_CHAR.
REQ-004 The module SHALL provide parameter CNT_W, default 16, giving the width of the traffic counters.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  1 = accept new words from the RX FIFO.
REQ-008 expand_en  input  1  1 = insert INS_CHAR after every forwarded TERM_CHAR.
REQ-009 rx_fifo_dout  input  DATA_W  RX FIFO head word, first-word-fall-through, valid while rx_fifo_empty=0.
REQ-010 rx_fifo_empty  input  1  RX FIFO empty flag.
REQ-011 rx_fifo_rd_en  output  1  pops the RX FIFO head this cycle.
REQ-012 tx_fifo_din  output  DATA_W  word written to the TX FIFO.
REQ-013 tx_fifo_full  input  1  TX FIFO full flag.
REQ-014 tx_fifo_wr_en  output  1  writes tx_fifo_din into the TX FIFO this cycle.
REQ-015 rx_count  output  CNT_W  number of words popped, modulo 2^CNT_W.
REQ-016 tx_count  output  CNT_W  number of words written, inserted words included, modulo 2^CNT_W.
REQ-017 busy  output  1  high while the holding register is occupied.

Function
REQ-018 The block SHALL hold one word plus a three-state FSM: EMPTY (no word held), DATA (holds a popped word), INS (holds INS_CHAR).
REQ-019 The write condition SHALL be defined as wr = (state != EMPTY) & !tx_fifo_full & !rst, and tx_fifo_wr_en SHALL equal wr.
REQ-020 tx_fifo_din SHALL equal the held word when wr=1, and SHALL be all-zero otherwise.
REQ-021 The define "term_hit" SHALL be: state=DATA & expand_en & held word == TERM_CHAR, with TERM_CHAR zero-extended or truncated to DATA_W.
REQ-022 rx_fifo_rd_en SHALL be driven as en & !rx_fifo_empty & !rst & (state=EMPTY | (wr & !term_hit)).
REQ-023 Latency from an RX pop to the matching TX write SHALL be exactly 1 cycle when tx_fifo_full=0.
REQ-024 Sustained throughput SHALL be 1 word per cycle when there is no insertion and no backpressure.
REQ-025 EMPTY transitions: on pop, load rx_fifo_dout and go to DATA; otherwise stay in EMPTY.
REQ-026 DATA transitions: with no wr, hold the word and stay in DATA.
REQ-027 DATA transitions: on wr with term_hit, load INS_CHAR and go to INS, with no pop in that cycle.
REQ-028 DATA transitions: on wr with a pop, load the new word and stay in DATA; on wr without a pop, go to EMPTY.
REQ-029 INS transitions: with no wr, stay in INS.
REQ-030 INS transitions: on wr with a pop, load the word and go to DATA; on wr without a pop, go to EMPTY.
REQ-031 expand_en SHALL be evaluated in the cycle the TERM_CHAR word is written, and changing it mid-stream SHALL NOT corrupt a pending INS.
REQ-032 When en=0, no new pop SHALL occur, and a held word (including a pending INS) SHALL still drain to the TX FIFO.
REQ-033 When tx_fifo_full=1, the held word SHALL be retained unchanged and no pop SHALL occur unless state=EMPTY.
REQ-034 rx_count SHALL increment by 1 on each rx_fifo_rd_en, and tx_count by 1 on each tx_fifo_wr_en; both SHALL wrap from all-ones to 0 with no flag.
REQ-035 busy SHALL be 1 exactly when state != EMPTY.

Reset
REQ-036 While rst=1: state=EMPTY, held word=0, rx_count=0, tx_count=0, and rx_fifo_rd_en, tx_fifo_wr_en, tx_fifo_din, busy all 0.
REQ-037 A reset asserted mid-stream SHALL discard the held word and any pending INS without writing them.
REQ-038 The first pop after reset deassertion SHALL occur no earlier than the first rising edge with rst=0.

Structure
REQ-039 A shared package fifo_loopback_pkg SHALL hold the FSM state encoding (EMPTY/DATA/INS) and the default TERM_CHAR/INS_CHAR constants.
REQ-040 The two counters SHALL be instances of one sub-module, loopback_counter, parametrised by CNT_W, with inputs clk, rst, inc and output count.

Verification
REQ-041 Stream 8'h41,8'h42,8'h43 with en=1, tx_fifo_full=0 -> TX receives 41,42,43 on consecutive cycles, each 1 cycle after its pop; rx_count=tx_count=3.
REQ-042 expand_en=1 with input 41,0D,42 -> TX sees 41,0D,0A,42; no pop in the cycle 0D is written; rx_count=3, tx_count=4.
REQ-043 Hold tx_fifo_full=1 for 5 cycles with word 55 held -> din/wr_en stay 0, no pops, busy=1; 55 is written on the first cycle full drops.
REQ-044 Drop en to 0 while state=INS -> 0A is still written, then busy=0 and no further pops.
REQ-045 CNT_W=4 with 17 words -> rx_count and tx_count both read 1.
REQ-046 Assert rst while 0D/INS is pending -> all outputs 0 immediately, 0A is never written, counters are 0.
